// File: rtl/clk_divider_nch_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master side drives enable/sync/mode/divisor; the divider answers with counts, clocks and ticks.
interface clk_divider_nch_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 2
);
   logic                   enable;
   logic                   sync;
   logic [NCH-1:0]         mode;
   logic [NCH*WIDTH-1:0]   divisor;
   logic [NCH*WIDTH-1:0]   div_cnt;
   logic [NCH-1:0]         div_clk;
   logic [NCH-1:0]         tick;

   modport master (
      output enable, sync, mode, divisor,
      input  div_cnt, div_clk, tick
   );

   modport slave (
      input  enable, sync, mode, divisor,
      output div_cnt, div_clk, tick
   );
endinterface

// File: rtl/clk_divider_nch.sv
// NCH independent programmable dividers on one clock, each with a registered divided clock,
// a one-cycle wrap tick and its live count; divisors are latched only at period boundaries.
module clk_divider_nch #(
   parameter int WIDTH = 8,
   parameter int NCH   = 2
) (
   input  logic               clk,
   input  logic               nreset,
   clk_divider_nch_if.slave   bus
);

   logic [NCH-1:0][WIDTH-1:0] div_d;
   logic [NCH-1:0][WIDTH-1:0] cnt_q;
   logic [NCH-1:0][WIDTH-1:0] shadow_q;
   logic [NCH-1:0]            div_clk_q;
   logic [NCH-1:0]            tick_q;
   logic [NCH-1:0]            wrap;

   assign div_d = bus.divisor;

   // Compare against the shadow copy so a divisor change never cuts a period short.
   always_comb begin
      // NOTE: default assigned first so every path drives wrap and no latch is inferred.
      wrap = '0;
      for (int i = 0; i < NCH; i++) begin
         wrap[i] = (cnt_q[i] == shadow_q[i]);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         // NOTE: these per-channel arrays are plain flops, not a RAM, so clearing them all
         // on the async reset is legal and keeps the first post-reset edge deterministic.
         cnt_q     <= '0;
         shadow_q  <= '0;
         div_clk_q <= '0;
         tick_q    <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            // NOTE: non-blocking assignments throughout, so every channel sees pre-edge values.
            if (bus.sync) begin
               cnt_q[i]     <= '0;
               shadow_q[i]  <= div_d[i];
               div_clk_q[i] <= 1'b0;
               tick_q[i]    <= 1'b0;
            end else if (!bus.enable) begin
               shadow_q[i]  <= div_d[i];
               tick_q[i]    <= 1'b0;
               if (bus.mode[i]) begin
                  div_clk_q[i] <= 1'b0;
               end
            end else if (wrap[i]) begin
               cnt_q[i]     <= '0;
               shadow_q[i]  <= div_d[i];
               tick_q[i]    <= 1'b1;
               div_clk_q[i] <= bus.mode[i] ? 1'b1 : ~div_clk_q[i];
            end else begin
               cnt_q[i]     <= cnt_q[i] + WIDTH'(1);
               tick_q[i]    <= 1'b0;
               if (bus.mode[i]) begin
                  div_clk_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.div_cnt = cnt_q;
   assign bus.div_clk = div_clk_q;
   assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_nch.sv
// Bench for clk_divider_nch: a per-cycle reference model feeds a scoreboard queue,
// plus directed period, sync, hold and async-reset checks.
module tb_clk_divider_nch;
   localparam int WIDTH = 8;
   localparam int NCH   = 2;

   typedef struct packed {
      logic [NCH*WIDTH-1:0] cnt;
      logic [NCH-1:0]       dclk;
      logic [NCH-1:0]       tick;
   } exp_t;

   logic clk = 1'b0;
   logic nreset;

   clk_divider_nch_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   clk_divider_nch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   logic [WIDTH-1:0] m_cnt [NCH];
   logic [WIDTH-1:0] m_s   [NCH];
   logic             m_clk [NCH];
   logic             m_tick[NCH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = '0; m_s[i] = '0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end
   endtask

   // Advance the model one edge with the current inputs, queue the prediction, then compare.
   task automatic step(input string tag);
      exp_t e, o;
      for (int i = 0; i < NCH; i++) begin
         logic [WIDTH-1:0] d;
         d = bus.divisor[i*WIDTH +: WIDTH];
         if (bus.sync) begin
            m_cnt[i] = '0; m_s[i] = d; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
         end else if (!bus.enable) begin
            m_tick[i] = 1'b0; m_s[i] = d;
            if (bus.mode[i]) m_clk[i] = 1'b0;
         end else if (m_cnt[i] == m_s[i]) begin
            m_cnt[i] = '0; m_tick[i] = 1'b1; m_s[i] = d;
            m_clk[i] = bus.mode[i] ? 1'b1 : ~m_clk[i];
         end else begin
            m_cnt[i] = m_cnt[i] + 1'b1; m_tick[i] = 1'b0;
            if (bus.mode[i]) m_clk[i] = 1'b0;
         end
         e.cnt[i*WIDTH +: WIDTH] = m_cnt[i];
         e.dclk[i] = m_clk[i];
         e.tick[i] = m_tick[i];
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      o = sb_q.pop_front();
      check({tag, "_cnt"},  32'(bus.div_cnt), 32'(o.cnt));
      check({tag, "_dclk"}, 32'(bus.div_clk), 32'(o.dclk));
      check({tag, "_tick"}, 32'(bus.tick),    32'(o.tick));
   endtask

   // Cycles until the next tick on channel ch, bounded.
   task automatic gap(input int ch, input int exp_n, input string tag);
      int n;
      n = 0;
      do begin
         step(tag);
         n++;
      end while (!bus.tick[ch] && n < 1000);
      check(tag, 32'(n), 32'(exp_n));
   endtask

   int ticks, high, first0, first1, both, n, hi, tg;
   logic prev;

   initial begin
      nreset = 1'b0;
      bus.enable = 1'b0; bus.sync = 1'b0; bus.mode = '0; bus.divisor = '0;
      model_reset();
      #2;
      check("rst_cnt",  32'(bus.div_cnt), 32'd0);
      check("rst_dclk", 32'(bus.div_clk), 32'd0);
      check("rst_tick", 32'(bus.tick),    32'd0);
      #10 nreset = 1'b1;

      // T1: D=3 toggle mode, tick every 4, div_clk period 8 with 50% duty
      bus.divisor = {8'd1, 8'd3};
      bus.sync = 1'b1; step("t1_sync"); bus.sync = 1'b0;
      bus.enable = 1'b1;
      ticks = 0; high = 0;
      for (int k = 0; k < 16; k++) begin
         step("t1");
         ticks += int'(bus.tick[0]);
         high  += int'(bus.div_clk[0]);
      end
      check("t1_ticks", 32'(ticks), 32'd4);
      check("t1_high",  32'(high),  32'd8);

      // T2: D changed mid-period finishes the old period, then uses the new one
      step("t2");
      check("t2_cnt1", 32'(bus.div_cnt[7:0]), 32'd1);
      bus.divisor[7:0] = 8'd5;
      step("t2"); step("t2"); step("t2");
      check("t2_old_wrap", 32'(bus.tick[0]), 32'd1);
      gap(0, 6, "t2_gap6");

      // T3: sync realigns channels; coincident ticks every lcm(3,5)=15
      bus.divisor = {8'd4, 8'd2};
      for (int k = 0; k < 5; k++) step("t3_run");
      bus.sync = 1'b1; step("t3_sync"); bus.sync = 1'b0;
      check("t3_sync_cnt",  32'(bus.div_cnt), 32'd0);
      check("t3_sync_dclk", 32'(bus.div_clk), 32'd0);
      first0 = -1; first1 = -1; both = -1;
      for (int k = 1; k <= 15; k++) begin
         step("t3");
         if (bus.tick[0] && first0 < 0) first0 = k;
         if (bus.tick[1] && first1 < 0) first1 = k;
         if (bus.tick[0] && bus.tick[1] && both < 0) both = k;
      end
      check("t3_first0", 32'(first0), 32'd3);
      check("t3_first1", 32'(first1), 32'd5);
      check("t3_both",   32'(both),   32'd15);
      n = 0;
      do begin
         step("t3_again");
         n++;
      end while (!(bus.tick[0] && bus.tick[1]) && n < 100);
      check("t3_both_period", 32'(n), 32'd15);

      // T4: D=0, ch0 pulse mode stays high, ch1 toggle mode toggles every cycle
      bus.divisor = '0; bus.mode = 2'b01;
      bus.sync = 1'b1; step("t4_sync"); bus.sync = 1'b0;
      hi = 0; tg = 0; prev = bus.div_clk[1];
      for (int k = 0; k < 6; k++) begin
         step("t4");
         hi += int'(bus.div_clk[0] & bus.tick[0]);
         tg += int'(bus.div_clk[1] != prev);
         prev = bus.div_clk[1];
      end
      check("t4_pulse_high", 32'(hi), 32'd6);
      check("t4_toggles",    32'(tg), 32'd6);

      // T5: enable low holds count and div_clk, resume continues 3,0
      bus.divisor = {8'd3, 8'd3}; bus.mode = '0;
      bus.sync = 1'b1; step("t5_sync"); bus.sync = 1'b0;
      step("t5"); step("t5");
      check("t5_cnt2", 32'(bus.div_cnt[7:0]), 32'd2);
      bus.enable = 1'b0;
      for (int k = 0; k < 10; k++) step("t5_hold");
      check("t5_held_cnt",  32'(bus.div_cnt[7:0]), 32'd2);
      check("t5_held_dclk", 32'(bus.div_clk[0]),   32'd0);
      bus.enable = 1'b1;
      step("t5_res");
      check("t5_res3", 32'(bus.div_cnt[7:0]), 32'd3);
      step("t5_res");
      check("t5_res0",  32'(bus.div_cnt[7:0]), 32'd0);
      check("t5_rtick", 32'(bus.tick[0]),      32'd1);

      // T6: async reset between edges, then D=255 full-range period
      bus.divisor = '0; bus.mode = 2'b01;
      bus.sync = 1'b1; step("t6_sync"); bus.sync = 1'b0;
      step("t6_pre"); step("t6_pre");
      check("t6_pre_dclk", 32'(bus.div_clk[0]), 32'd1);
      #3 nreset = 1'b0;
      #1;
      model_reset();
      check("t6_rst_cnt",  32'(bus.div_cnt), 32'd0);
      check("t6_rst_dclk", 32'(bus.div_clk), 32'd0);
      check("t6_rst_tick", 32'(bus.tick),    32'd0);
      bus.divisor = {8'd255, 8'd255}; bus.mode = '0;
      #2 nreset = 1'b1;
      step("t6_first");
      check("t6_first_tick", 32'(bus.tick[0]), 32'd1);
      gap(0, 256, "t6_gap256");
      check("t6_wrap_cnt", 32'(bus.div_cnt[7:0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
